// File: rtl/dvs_fifo_bus_arbiter.sv
// dvs_fifo_bus_arbiter
// Round-robin owner selection for the single DVS event FIFO read port.
// One consumer at a time gets a grant pulse; only its rd_en reaches the FIFO,
// then the bus is held for one capture cycle before re-arbitration.
// Optional WAIT_RD watchdog: define DVS_FIFO_ARB_WATCHDOG_EN to enable it.
module dvs_fifo_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         rd_en,
    input  logic                       fifo_empty,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       fifo_rd_en,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       protocol_err,
    output logic                       timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     owner_r;
    logic [IDX_W-1:0]     rr_ptr_r;
    logic [IDX_W-1:0]     pick_s;
    logic [NUM_REQ-1:0]   grant_r;
    logic                 busy_r;
    logic                 perr_r;
    logic                 timeout_r;
    logic [NUM_REQ-1:0]   owner_mask_s;
    logic                 owner_rd_s;
    logic                 stray_s;
    logic                 expire_s;
    logic                 accept_s;

    // (base + off) modulo NUM_REQ; both operands are already below NUM_REQ
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [SUM_W-1:0] off);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Only the owner's read is legal, and only while waiting for it
    assign owner_mask_s = (state_r == ST_WAIT_RD) ? (NUM_REQ'(1) << owner_r) : {NUM_REQ{1'b0}};
    assign owner_rd_s   = |(rd_en & owner_mask_s);
    assign stray_s      = |(rd_en & ~owner_mask_s);
    assign accept_s     = (state_r == ST_IDLE) && (state_s == ST_GRANT);

`ifdef DVS_FIFO_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_r;

    assign expire_s = (state_r == ST_WAIT_RD) && !owner_rd_s &&
                      (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in WAIT_RD; cleared whenever the FSM is elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT_RD) && (state_s == ST_WAIT_RD)) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
        end else begin
            wd_cnt_r <= {CNT_W{1'b0}};
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Round-robin pick: lowest offset from rr_ptr with a pending request wins
    always_comb begin
        pick_s = rr_ptr_r;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_s = req[wrap_add(rr_ptr_r, SUM_W'(k))] ? wrap_add(rr_ptr_r, SUM_W'(k)) : pick_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((|req) && !fifo_empty) begin
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: state_s = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (owner_rd_s) begin
                    state_s = ST_HOLD;
                end else if (expire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_RD;
                end
            end
            ST_HOLD: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, ownership, round-robin pointer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            owner_r   <= {IDX_W{1'b0}};
            rr_ptr_r  <= {IDX_W{1'b0}};
            grant_r   <= {NUM_REQ{1'b0}};
            busy_r    <= 1'b0;
            perr_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s != ST_IDLE);
            perr_r    <= perr_r | stray_s;
            timeout_r <= expire_s;
            if (accept_s) begin
                owner_r <= pick_s;
                grant_r <= NUM_REQ'(1) << pick_s;
            end else begin
                owner_r <= owner_r;
                grant_r <= {NUM_REQ{1'b0}};
            end
            // A completed or abandoned read moves priority past the owner
            if ((state_r == ST_WAIT_RD) && (owner_rd_s || expire_s)) begin
                rr_ptr_r <= wrap_add(owner_r, SUM_W'(1));
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign grant        = grant_r;
    assign fifo_rd_en   = owner_rd_s;
    assign owner        = owner_r;
    assign busy         = busy_r;
    assign protocol_err = perr_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_dvs_fifo_bus_arbiter.sv
// Scoreboard bench for dvs_fifo_bus_arbiter: stimulus pushes expected grant
// owners and expected read owners; a monitor pops and compares on each grant
// and each fifo_rd_en cycle. Inputs change 1 ns after the rising edge,
// outputs are sampled 1 ns after the falling edge.
module tb_dvs_fifo_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] rd_en;
    logic       fifo_empty;
    logic [3:0] grant;
    logic       fifo_rd_en;
    logic [1:0] owner;
    logic       busy;
    logic       protocol_err;
    logic       timeout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_q[$];
    int   rd_q[$];
    int   n_grant = 0;
    int   n_rd = 0;
    int   last_grant_cyc = 0;
    int   prev_grant_cyc = 0;
    int   n_timeout = 0;
    int   last_to_cyc = 0;
    logic to_busy = 1'b0;
    logic to_allowed = 1'b0;
    logic perr_exp = 1'b0;
    logic [3:0] no_rd_mask = 4'b0000;

    dvs_fifo_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rd_en(rd_en), .fifo_empty(fifo_empty),
        .grant(grant), .fifo_rd_en(fifo_rd_en), .owner(owner), .busy(busy),
        .protocol_err(protocol_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n;
        n = 0;
        while (n_grant < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant_count", n_grant, target);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("return_idle_busy", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_protocol_err"}, protocol_err, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or a read
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (grant != 4'b0000) begin
                    n_grant++;
                    prev_grant_cyc = last_grant_cyc;
                    last_grant_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("grant_unexpected", grant, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_onehot", grant, 1 << e);
                        check("grant_owner", owner, e);
                    end
                end
                if (fifo_rd_en) begin
                    n_rd++;
                    if (rd_q.size() == 0) begin
                        check("fifo_rd_unexpected", 1, 0);
                    end else begin
                        e = rd_q.pop_front();
                        check("fifo_rd_owner", owner, e);
                    end
                end
                check("protocol_err_level", protocol_err, perr_exp);
                if (timeout) begin
                    n_timeout++;
                    last_to_cyc = cyc;
                    to_busy = busy;
                    if (!to_allowed) begin
                        check("timeout_unexpected", 1, 0);
                    end
                end
            end
        end
    end

    // Well-behaved consumers: read one cycle after their grant unless masked
    initial begin
        logic [3:0] g;
        int gi;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && grant != 4'b0000 && (grant & no_rd_mask) == 4'b0000) begin
                g = grant;
                gi = 0;
                for (int i = 0; i < 4; i++) begin
                    if (g[i]) gi = i;
                end
                @(posedge clk);
                #1;
                rd_en = rd_en | g;
                rd_q.push_back(gi);
                @(posedge clk);
                #1;
                rd_en = rd_en & ~g;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit actual=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int base;
        int t0;
        int g;
        int rd_base;
        rst_n = 1'b1;
        req = 4'b0000;
        rd_en = 4'b0000;
        fifo_empty = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_busy", busy, 0);
        check("post_reset_grant", grant, 0);

        // Fairness: all four requesting, rr_ptr starts at 0
        for (int i = 0; i < 8; i++) exp_q.push_back(i % 4);
        req = 4'b1111;
        wait_grants(8, 80);
        step();
        req = 4'b0000;
        wait_idle(10);
        check("fair_queue_drained", exp_q.size(), 0);

        // Single requester wins back-to-back, 4 cycles apart
        base = n_grant;
        rd_base = n_rd;
        exp_q.push_back(0);
        exp_q.push_back(0);
        req = 4'b0001;
        wait_grants(base + 2, 20);
        check("single_grant_spacing", last_grant_cyc - prev_grant_cyc, 4);
        step();
        req = 4'b0000;
        wait_idle(10);
        check("single_reads", n_rd - rd_base, 2);

        // Empty FIFO blocks arbitration; rr_ptr is now 1
        fifo_empty = 1'b1;
        req = 4'b0010;
        base = n_grant;
        repeat (10) step();
        check("empty_no_grant", n_grant, base);
        check("empty_busy", busy, 0);
        exp_q.push_back(1);
        fifo_empty = 1'b0;
        t0 = cyc;
        wait_grants(base + 1, 10);
        check("empty_release_latency_ok",
              ((last_grant_cyc - t0) >= 1 && (last_grant_cyc - t0) <= 2) ? 1 : 0, 1);
        step();
        req = 4'b0000;
        wait_idle(10);

        // Stalled owner 2 (rr_ptr is now 2)
        no_rd_mask = 4'b0100;
        req = 4'b1111;
        base = n_grant;
        exp_q.push_back(2);
        exp_q.push_back(3);
        wait_grants(base + 1, 10);
        g = last_grant_cyc;
`ifdef DVS_FIFO_ARB_WATCHDOG_EN
        to_allowed = 1'b1;
        wait_grants(base + 2, 30);
        check("wd_timeout_pulses", n_timeout, 1);
        check("wd_timeout_delay", last_to_cyc - g, 9);
        check("wd_timeout_in_idle_busy", to_busy, 0);
        check("wd_regrant_delay", last_grant_cyc - last_to_cyc, 1);
        to_allowed = 1'b0;
`else
        repeat (20) step();
        check("nowd_still_busy", busy, 1);
        check("nowd_no_new_grant", n_grant, base + 1);
        check("nowd_no_timeout", n_timeout, 0);
        rd_en[2] = 1'b1;
        rd_q.push_back(2);
        step();
        rd_en[2] = 1'b0;
        wait_grants(base + 2, 10);
`endif
        step();
        req = 4'b0000;
        no_rd_mask = 4'b0000;
        wait_idle(10);

        // Stray read from consumer 3 while owner 1 waits (rr_ptr is now 0)
        no_rd_mask = 4'b0010;
        req = 4'b0010;
        base = n_grant;
        exp_q.push_back(1);
        wait_grants(base + 1, 10);
        step();
        rd_en[3] = 1'b1;
        @(negedge clk);
        #1;
        check("stray_fifo_rd_en", fifo_rd_en, 0);
        step();
        rd_en[3] = 1'b0;
        perr_exp = 1'b1;
        check("stray_protocol_err", protocol_err, 1);
        check("stray_still_waiting", busy, 1);
        rd_en[1] = 1'b1;
        rd_q.push_back(1);
        step();
        rd_en[1] = 1'b0;
        req = 4'b0000;
        no_rd_mask = 4'b0000;
        wait_idle(10);
        repeat (3) step();
        check("protocol_err_sticky", protocol_err, 1);

        // Reset in HOLD of a transaction owned by 2 (rr_ptr is now 2)
        req = 4'b0100;
        base = n_grant;
        exp_q.push_back(2);
        wait_grants(base + 1, 10);
        step();
        req = 4'b0000;
        step();
        check("hold_busy", busy, 1);
        check("hold_owner", owner, 2);
        #1;
        rst_n = 1'b0;
        perr_exp = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step();
        step();
        rst_n = 1'b1;
        req = 4'b1000;
        base = n_grant;
        exp_q.push_back(3);
        wait_grants(base + 1, 10);
        step();
        req = 4'b0000;
        wait_idle(10);

        check("final_grant_queue", exp_q.size(), 0);
        check("final_read_queue", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvs_fifo_bus_arbiter.md
# dvs_fifo_bus_arbiter

Round-robin arbiter that shares the single DVS event FIFO read port among `NUM_REQ` event-to-RAVENS consumers. It accepts level requests and issues a one-cycle grant pulse to one consumer. It forwards only that consumer's read enable to the FIFO, then holds the bus through the consumer's data-capture cycle before re-arbitrating. It sits between the event FIFO and the array of per-core event-to-RAVENS converters.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of consumers; must be ≥2.
- `TIMEOUT_CYCLES`, default 8: cycles allowed in WAIT_RD before the watchdog fires; must be ≥1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, NUM_REQ: per-consumer level request (consumer's `fifo_req`).
- `rd_en`, input, NUM_REQ: per-consumer FIFO read enable.
- `fifo_empty`, input, 1: event FIFO empty flag.
- `grant`, output, NUM_REQ: one-hot, single-cycle grant pulse.
- `fifo_rd_en`, output, 1: read enable to the FIFO.
- `owner`, output, $clog2(NUM_REQ): index of the current or last bus owner.
- `busy`, output, 1: high in any state other than IDLE.
- `protocol_err`, output, 1: sticky; set when any non-owner asserts `rd_en`.
- `timeout`, output, 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, GRANT, WAIT_RD, HOLD.
- **IDLE:**
  - If `(|req) && !fifo_empty`, go to GRANT and latch `owner` = first set `req` bit scanning upward from `rr_ptr`, wrapping at NUM_REQ-1 → 0.
  - Otherwise stay in IDLE.
- **GRANT:** `grant[owner]`=1 for exactly this cycle. Next state is WAIT_RD.
- **WAIT_RD:**
  - `fifo_rd_en = rd_en[owner]` (combinational).
  - If `rd_en[owner]`, go to HOLD and set `rr_ptr` = (owner+1) mod NUM_REQ.
- **HOLD:** bus is reserved while the consumer samples the FIFO output. Next state is IDLE.
- `fifo_rd_en` is 0 in IDLE, GRANT and HOLD, regardless of the `rd_en` inputs.
- `rd_en[i]` with i≠owner, or any `rd_en` outside WAIT_RD, sets `protocol_err`. Such an assertion never reaches the FIFO. Only reset clears `protocol_err`.
- A `req` that drops during GRANT or WAIT_RD does not abort the transaction. Only `rd_en` or the watchdog ends WAIT_RD.
- `fifo_empty` is sampled only in IDLE. Once granted, the transaction completes even if the FIFO drains.
- Simultaneous requests are resolved purely by `rr_ptr`. A sole requester may win back-to-back transactions.

## Timing
- Reset values:
  - `grant`=0, `fifo_rd_en`=0, `owner`=0, `busy`=0, `protocol_err`=0, `timeout`=0.
  - Internal: state=IDLE, `rr_ptr`=0, watchdog counter=0.
- Request accepted at edge N (IDLE) → `grant` high during cycle N+1.
- The consumer raises `rd_en` in cycle N+2; `fifo_rd_en` is high in the same cycle.
- HOLD occupies cycle N+3. IDLE resumes at N+4.
- Next `grant` comes no earlier than cycle N+5. A transaction occupies 4 cycles minimum.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronously). No grant or read is replayed.

## Configuration
- Macro: `DVS_FIFO_ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter runs in WAIT_RD.
  - After `TIMEOUT_CYCLES` cycles in WAIT_RD without `rd_en[owner]`, the FSM goes to IDLE and pulses `timeout` for one cycle.
  - `rr_ptr` advances past the stalled owner.
- **Undefined:**
  - WAIT_RD waits indefinitely.
  - `timeout` is tied to 0.
  - No counter logic is synthesized.

## Test plan
- **Single request:** `req`=4'b0001, FIFO non-empty, consumer asserts `rd_en[0]` one cycle after the grant.
  - `grant`=0001 for 1 cycle, `fifo_rd_en` high for 1 cycle, `owner`=0.
  - The next grant lands exactly 4 cycles after the first.
- **Fairness:** `req`=4'b1111 held for 8 transactions with well-behaved consumers.
  - Grant order is 0,1,2,3,0,1,2,3.
- **Empty FIFO:** `req`=4'b0010 with `fifo_empty`=1 for 10 cycles.
  - No grant is issued.
  - Deassert `fifo_empty`; `grant`=0010 follows 2 cycles later.
- **Stray read:** `rd_en[3]` pulsed while owner=1 is in WAIT_RD.
  - `fifo_rd_en` stays 0 for that pulse and `protocol_err` goes high.
  - `protocol_err` stays high until `rst_n` is asserted.
- **Watchdog:** with `DVS_FIFO_ARB_WATCHDOG_EN` defined, TIMEOUT_CYCLES=8, owner=2 never asserts `rd_en`.
  - `timeout` pulses 8 cycles after WAIT_RD entry and the FSM returns to IDLE.
  - With `req`=4'b1111, the next grant goes to consumer 3.
  - Without the macro, the FSM stays in WAIT_RD.
- **Reset mid-operation:** assert `rst_n` low during HOLD.
  - All outputs return to reset values immediately (asynchronously).
  - After release with `req`=4'b1000, the FSM re-arbitrates from `rr_ptr`=0 and grants consumer 3.
